// File: rtl/max_pool.sv
// max_pool: streaming 2-D max pooling over non-overlapping STRIDE x STRIDE
// windows of a raster-ordered (channel, row, column) feature-map stream.
//
// State table
//   IDLE | waiting for enable; position counters held at zero
//   RUN  | accepting samples while enable && input_valid
//   DONE | frame fully accepted; pool_done pulses next cycle
//   BP   | routing complete; backprop_done pulses next cycle
//
// Ports
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   enable          gates sample acceptance and FSM progress
//   input_data      signed Q8.8 sample, qualified by input_valid
//   pooled_output   registered window maximum, held until next strobe
//   output_error    winner position inside window (row*STRIDE + col)
//   output_valid    one-cycle strobe per pooled window
//   pool_done       one-cycle pulse the cycle after the last accepted sample's strobe slot
//   backprop_done   one-cycle pulse the cycle after pool_done
//
// Build option: define POOL_RELU_EN to clamp negative window maxima to zero
// on pooled_output (output_error is unaffected).
module max_pool #(
    parameter int INPUT_WIDTH    = 62,
    parameter int INPUT_HEIGHT   = 62,
    parameter int INPUT_CHANNELS = 30,
    parameter int STRIDE         = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic signed [15:0] input_data,
    input  logic               input_valid,
    output logic signed [15:0] pooled_output,
    output logic               output_valid,
    output logic               pool_done,
    output logic [15:0]        output_error,
    output logic               backprop_done
);

    localparam int POOL_W = INPUT_WIDTH / STRIDE;
    localparam int X_LIM  = POOL_W * STRIDE;
    localparam int Y_LIM  = (INPUT_HEIGHT / STRIDE) * STRIDE;
    localparam int XW     = (INPUT_WIDTH > 1) ? $clog2(INPUT_WIDTH) : 1;
    localparam int YW     = (INPUT_HEIGHT > 1) ? $clog2(INPUT_HEIGHT) : 1;
    localparam int CW     = (INPUT_CHANNELS > 1) ? $clog2(INPUT_CHANNELS) : 1;
    localparam int WW     = $clog2(STRIDE);
    localparam int OXW    = (POOL_W > 1) ? $clog2(POOL_W) : 1;
    localparam int IDXW   = $clog2(STRIDE * STRIDE);

    typedef enum logic [1:0] {IDLE, RUN, DONE, BP} state_t;

    state_t state, state_nxt;
    logic   pool_done_nxt, backprop_done_nxt;

    logic [XW-1:0]  x;
    logic [YW-1:0]  y;
    logic [CW-1:0]  c;
    logic [WW-1:0]  wx, wy;
    logic [OXW-1:0] ox;

    logic accept, last_x, last_y, last_c, last_sample;
    logic pool_en, win_first, win_last;
    logic [IDXW-1:0] pos;

    logic signed [15:0] lb_val [POOL_W];
    logic [IDXW-1:0]    lb_idx [POOL_W];
    logic signed [15:0] cand_val;
    logic [IDXW-1:0]    cand_idx;

    assign accept      = (state == RUN) && enable && input_valid;
    assign last_x      = (int'(x) == INPUT_WIDTH - 1);
    assign last_y      = (int'(y) == INPUT_HEIGHT - 1);
    assign last_c      = (int'(c) == INPUT_CHANNELS - 1);
    assign last_sample = last_x && last_y && last_c;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = RUN;
            RUN:     if (accept && last_sample) state_nxt = DONE;
            DONE:    state_nxt = BP;
            BP:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pool_done_nxt     = (state == DONE);
        backprop_done_nxt = (state == BP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pool_done     <= 1'b0;
            backprop_done <= 1'b0;
        end else begin
            pool_done     <= pool_done_nxt;
            backprop_done <= backprop_done_nxt;
        end
    end

    // ---------------- position counters ----------------
    // wx/wy/ox track x%S, y%S, x/S incrementally so no dividers are needed.
    // ox saturates at the last pooled column; columns past it are truncated
    // anyway, so its value there is never used.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x  <= '0;
            y  <= '0;
            c  <= '0;
            wx <= '0;
            wy <= '0;
            ox <= '0;
        end else if (state == IDLE) begin
            x  <= '0;
            y  <= '0;
            c  <= '0;
            wx <= '0;
            wy <= '0;
            ox <= '0;
        end else if (accept) begin
            if (last_x) begin
                x  <= '0;
                wx <= '0;
                ox <= '0;
                if (last_y) begin
                    y  <= '0;
                    wy <= '0;
                    c  <= last_c ? '0 : c + CW'(1);
                end else begin
                    y  <= y + YW'(1);
                    wy <= (int'(wy) == STRIDE - 1) ? '0 : wy + WW'(1);
                end
            end else begin
                x <= x + XW'(1);
                if (int'(wx) == STRIDE - 1) begin
                    wx <= '0;
                    if (int'(ox) != POOL_W - 1) ox <= ox + OXW'(1);
                end else begin
                    wx <= wx + WW'(1);
                end
            end
        end
    end

    // ---------------- pooling datapath ----------------
    assign pool_en   = accept && (int'(x) < X_LIM) && (int'(y) < Y_LIM);
    assign win_first = (wx == '0) && (wy == '0);
    assign win_last  = (int'(wx) == STRIDE - 1) && (int'(wy) == STRIDE - 1);
    assign pos       = IDXW'(int'(wy) * STRIDE + int'(wx));

    // Strict compare: on a tie the earlier raster position keeps the win.
    always_comb begin
        cand_val = lb_val[ox];
        cand_idx = lb_idx[ox];
        if (win_first || (input_data > lb_val[ox])) begin
            cand_val = input_data;
            cand_idx = pos;
        end
    end

    always_ff @(posedge clk) begin
        if (pool_en) begin
            lb_val[ox] <= cand_val;
            lb_idx[ox] <= cand_idx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            output_valid  <= 1'b0;
            pooled_output <= '0;
            output_error  <= '0;
        end else begin
            output_valid <= pool_en && win_last;
            if (pool_en && win_last) begin
`ifdef POOL_RELU_EN
                pooled_output <= (cand_val < 0) ? 16'sd0 : cand_val;
`else
                pooled_output <= cand_val;
`endif
                output_error  <= 16'(cand_idx);
            end
        end
    end

endmodule

// File: tb/tb_max_pool.sv
module tb_max_pool;

    localparam int S  = 2;
    localparam int AW = 4;
    localparam int AH = 4;
    localparam int AC = 1;
    localparam int BW = 5;
    localparam int BH = 5;
    localparam int BC = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    logic        en_a = 1'b0, vld_a = 1'b0, en_b = 1'b0, vld_b = 1'b0;
    logic [15:0] din_a = '0, din_b = '0;
    logic [15:0] po_a, oe_a, po_b, oe_b;
    logic        ov_a, pd_a, bp_a, ov_b, pd_b, bp_b;

    int n_chk = 0;
    int n_pass = 0;

    logic [31:0]        qa[$];
    logic [31:0]        qb[$];
    logic signed [15:0] frame[$];
    logic [31:0]        e;

    int   pd_cnt_a = 0, pd_cnt_b = 0, bp_cnt_a = 0, bp_cnt_b = 0, strobes_b = 0;
    int   exp_frames_a = 0, exp_frames_b = 0;
    logic prev_ov_a = 1'b0, prev_pd_a = 1'b0, prev_pd_b = 1'b0;

    always #5 clk = ~clk;

    max_pool #(.INPUT_WIDTH(AW), .INPUT_HEIGHT(AH), .INPUT_CHANNELS(AC), .STRIDE(S)) u_a (
        .clk(clk), .reset(reset), .enable(en_a), .input_data(din_a), .input_valid(vld_a),
        .pooled_output(po_a), .output_valid(ov_a), .pool_done(pd_a),
        .output_error(oe_a), .backprop_done(bp_a)
    );

    max_pool #(.INPUT_WIDTH(BW), .INPUT_HEIGHT(BH), .INPUT_CHANNELS(BC), .STRIDE(S)) u_b (
        .clk(clk), .reset(reset), .enable(en_b), .input_data(din_b), .input_valid(vld_b),
        .pooled_output(po_b), .output_valid(ov_b), .pool_done(pd_b),
        .output_error(oe_b), .backprop_done(bp_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d", name, act, exp);
    endtask

    // Reference: for every window, scan its samples in raster order and keep
    // the first strictly-greater one.
    task automatic model(input int which, input int w, input int h, input int c_n);
        int base, bi;
        logic signed [15:0] best, v;
        for (int ch = 0; ch < c_n; ch++)
            for (int oy = 0; oy < h / S; oy++)
                for (int ox = 0; ox < w / S; ox++) begin
                    base = ch * w * h + oy * S * w + ox * S;
                    best = frame[base];
                    bi   = 0;
                    for (int k = 1; k < S * S; k++) begin
                        v = frame[base + (k / S) * w + (k % S)];
                        if (v > best) begin
                            best = v;
                            bi   = k;
                        end
                    end
`ifdef POOL_RELU_EN
                    if (best < 0) best = 16'sd0;
`endif
                    if (which == 0) qa.push_back({16'(bi), best});
                    else            qb.push_back({16'(bi), best});
                end
    endtask

    task automatic fill_random(input int n, input bit full);
        int r;
        frame.delete();
        for (int i = 0; i < n; i++) begin
            if (full) r = int'($urandom_range(0, 65535));
            else      r = int'($urandom_range(0, 6)) - 3;
            frame.push_back(16'(r));
        end
    endtask

    task automatic drive(input int which, input logic en, input logic vld, input logic [15:0] d);
        if (which == 0) begin
            en_a = en; vld_a = vld; din_a = d;
        end else begin
            en_b = en; vld_b = vld; din_b = d;
        end
    endtask

    task automatic stream(input int which, input int n, input int drop_at);
        @(negedge clk);
        drive(which, 1'b1, 1'b0, 16'h0);
        for (int i = 0; i < n; i++) begin
            if (i == drop_at)
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    drive(which, 1'b0, 1'b1, 16'($urandom));
                end
            @(negedge clk);
            drive(which, 1'b1, 1'b1, frame[i]);
        end
        @(negedge clk);
        drive(which, 1'b1, 1'b0, 16'h0);
    endtask

    task automatic wait_bp(input int which);
        int k;
        k = 0;
        while (k < 50 && !((which == 0) ? bp_a : bp_b)) begin
            @(negedge clk);
            k++;
        end
        chk((which == 0) ? "a_bp_timeout" : "b_bp_timeout", int'(k < 50), 1);
        drive(which, 1'b0, 1'b0, 16'h0);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (ov_a) begin
                chk("a_strobe_expected", int'(qa.size() > 0), 1);
                if (qa.size() > 0) begin
                    e = qa.pop_front();
                    chk("a_value", int'(po_a), int'(e[15:0]));
                    chk("a_index", int'(oe_a), int'(e[31:16]));
                end
            end
            if (pd_a) begin
                pd_cnt_a++;
                chk("a_done_after_last_strobe", int'(prev_ov_a), 1);
                chk("a_all_windows_out", qa.size(), 0);
            end
            if (bp_a || prev_pd_a) begin
                chk("a_bp_follows_done", int'(bp_a), int'(prev_pd_a));
                if (bp_a) bp_cnt_a++;
            end
            if (ov_b) begin
                strobes_b++;
                chk("b_strobe_expected", int'(qb.size() > 0), 1);
                if (qb.size() > 0) begin
                    e = qb.pop_front();
                    chk("b_value", int'(po_b), int'(e[15:0]));
                    chk("b_index", int'(oe_b), int'(e[31:16]));
                end
            end
            if (pd_b) begin
                pd_cnt_b++;
                chk("b_strobes_per_frame", strobes_b, (BW / S) * (BH / S) * BC);
                chk("b_all_windows_out", qb.size(), 0);
                strobes_b = 0;
            end
            if (bp_b || prev_pd_b) begin
                chk("b_bp_follows_done", int'(bp_b), int'(prev_pd_b));
                if (bp_b) bp_cnt_b++;
            end
        end
        prev_ov_a = ov_a;
        prev_pd_a = pd_a;
        prev_pd_b = pd_b;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, actual running required finished");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_a_out", int'(po_a), 0);
        chk("rst_a_err", int'(oe_a), 0);
        chk("rst_a_flags", int'({ov_a, pd_a, bp_a}), 0);
        chk("rst_b_out", int'(po_b), 0);
        chk("rst_b_err", int'(oe_b), 0);
        chk("rst_b_flags", int'({ov_b, pd_b, bp_b}), 0);
        reset = 1'b0;

        // Ramp 0..15: maxima 5, 7, 13, 15, all at position 3.
        frame.delete();
        for (int i = 0; i < 16; i++) frame.push_back(16'(i));
        model(0, AW, AH, AC);
        stream(0, 16, -1);
        wait_bp(0);
        exp_frames_a++;

        // All-negative window and a tie window.
        fill_random(16, 1'b1);
        frame[0] = -16'sd5; frame[1] = -16'sd2; frame[4] = -16'sd9; frame[5] = -16'sd3;
        frame[2] = 16'sd7;  frame[3] = 16'sd7;  frame[6] = 16'sd3;  frame[7] = 16'sd7;
        model(0, AW, AH, AC);
        stream(0, 16, -1);
        wait_bp(0);
        exp_frames_a++;

        // Enable dropped for 3 cycles with garbage on the bus.
        fill_random(16, 1'b1);
        model(0, AW, AH, AC);
        stream(0, 16, 7);
        wait_bp(0);
        exp_frames_a++;

        // Abort mid-frame right after the first window strobe.
        fill_random(16, 1'b1);
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(0, 1'b1, 1'b1, frame[i]);
        end
        @(posedge clk);
        #2;
        chk("abort_strobe_live", int'(ov_a), 1);
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 16'h0);
        #1;
        chk("abort_out_zero", int'(po_a), 0);
        chk("abort_err_zero", int'(oe_a), 0);
        chk("abort_flags_zero", int'({ov_a, pd_a, bp_a}), 0);
        qa.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // Fresh frame after abort.
        fill_random(16, 1'b1);
        model(0, AW, AH, AC);
        stream(0, 16, -1);
        wait_bp(0);
        exp_frames_a++;

        // Small value range on A: frequent ties and negatives.
        fill_random(16, 1'b0);
        model(0, AW, AH, AC);
        stream(0, 16, 3);
        wait_bp(0);
        exp_frames_a++;

        // Odd geometry with truncated row/column, two channels.
        fill_random(BW * BH * BC, 1'b1);
        model(1, BW, BH, BC);
        stream(1, BW * BH * BC, 20);
        wait_bp(1);
        exp_frames_b++;

        fill_random(BW * BH * BC, 1'b0);
        model(1, BW, BH, BC);
        stream(1, BW * BH * BC, -1);
        wait_bp(1);
        exp_frames_b++;

        repeat (5) @(negedge clk);
        chk("a_done_pulses", pd_cnt_a, exp_frames_a);
        chk("a_bp_pulses", bp_cnt_a, exp_frames_a);
        chk("b_done_pulses", pd_cnt_b, exp_frames_b);
        chk("b_bp_pulses", bp_cnt_b, exp_frames_b);
        chk("a_leftover", qa.size(), 0);
        chk("b_leftover", qb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
